// File: rtl/date_sequencer.sv
// Calendar date register (day/month/year) advanced by a day tick, with a
// validated valid/ready load path and a sticky error state cleared by err_clr.
module date_sequencer #(
  parameter int unsigned DAYS_PER_MONTH  = 30,
  parameter int unsigned MONTHS_PER_YEAR = 12,
  parameter int unsigned YEAR_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4:0]        load_day,
  input  logic [3:0]        load_month,
  input  logic              err_clr,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              err
);

  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam logic [DAY_W-1:0]   LP_LAST_DAY   = DAY_W'(DAYS_PER_MONTH);
  localparam logic [MONTH_W-1:0] LP_LAST_MONTH = MONTH_W'(MONTHS_PER_YEAR);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_t;

  state_t              r_state;
  logic [DAY_W-1:0]    r_day;
  logic [MONTH_W-1:0]  r_month;
  logic [YEAR_W-1:0]   r_year;
  logic                r_month_wrap;
  logic                r_year_wrap;
  logic                r_err;
  logic                r_ready;

  state_t              w_state_nxt;
  logic [DAY_W-1:0]    w_day_nxt;
  logic [MONTH_W-1:0]  w_month_nxt;
  logic [YEAR_W-1:0]   w_year_nxt;
  logic                w_month_wrap_nxt;
  logic                w_year_wrap_nxt;
  logic                w_accept;
  logic                w_legal;

  assign w_accept = load_valid && r_ready;
  assign w_legal  = (load_day != '0) && (load_day <= LP_LAST_DAY) &&
                    (load_month != '0) && (load_month <= LP_LAST_MONTH);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_day        <= DAY_W'(1);
      r_month      <= MONTH_W'(1);
      r_year       <= '0;
      r_month_wrap <= 1'b0;
      r_year_wrap  <= 1'b0;
      r_err        <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_day        <= w_day_nxt;
      r_month      <= w_month_nxt;
      r_year       <= w_year_nxt;
      r_month_wrap <= w_month_wrap_nxt;
      r_year_wrap  <= w_year_wrap_nxt;
      r_err        <= (w_state_nxt == ST_ERROR);
      r_ready      <= 1'b1;
    end
  end

  // Priority: accepted load, then err_clr, then tick; lower ones are dropped
  always_comb begin
    w_state_nxt      = r_state;
    w_day_nxt        = r_day;
    w_month_nxt      = r_month;
    w_year_nxt       = r_year;
    w_month_wrap_nxt = 1'b0;
    w_year_wrap_nxt  = 1'b0;
    if (w_accept) begin
      if (w_legal) begin
        w_day_nxt   = load_day;
        w_month_nxt = load_month;
        w_state_nxt = ST_RUN;
      end else begin
        w_state_nxt = ST_ERROR;
      end
    end else if (err_clr) begin
      w_state_nxt = ST_RUN;
    end else if (tick && (r_state == ST_RUN)) begin
      if (r_day < LP_LAST_DAY) begin
        w_day_nxt = r_day + DAY_W'(1);
      end else begin
        w_day_nxt        = DAY_W'(1);
        w_month_wrap_nxt = 1'b1;
        if (r_month < LP_LAST_MONTH) begin
          w_month_nxt = r_month + MONTH_W'(1);
        end else begin
          w_month_nxt     = MONTH_W'(1);
          w_year_nxt      = r_year + YEAR_W'(1);
          w_year_wrap_nxt = 1'b1;
        end
      end
    end
  end

  assign load_ready = r_ready;
  assign day        = r_day;
  assign month      = r_month;
  assign year       = r_year;
  assign month_wrap = r_month_wrap;
  assign year_wrap  = r_year_wrap;
  assign err        = r_err;

endmodule

// File: tb/tb_date_sequencer.sv
// Directed self-checking bench for date_sequencer.
module tb_date_sequencer;

  localparam int unsigned YEAR_W = 7;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              load_valid;
  logic              load_ready;
  logic [4:0]        load_day;
  logic [3:0]        load_month;
  logic              err_clr;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              month_wrap;
  logic              year_wrap;
  logic              err;

  int n_tests;
  int n_failed;

  date_sequencer #(
    .DAYS_PER_MONTH (30),
    .MONTHS_PER_YEAR(12),
    .YEAR_W         (YEAR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_day  (load_day),
    .load_month(load_month),
    .err_clr   (err_clr),
    .day       (day),
    .month     (month),
    .year      (year),
    .month_wrap(month_wrap),
    .year_wrap (year_wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs sampled 1ns later, pulse inputs then cleared
  task automatic step();
    @(posedge clk);
    #1;
    tick       = 1'b0;
    load_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic do_load(input int d, input int m);
    load_valid = 1'b1;
    load_day   = 5'(d);
    load_month = 4'(m);
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check({tag, ".day"},   int'(day),   d);
    check({tag, ".month"}, int'(month), m);
    check({tag, ".year"},  int'(year),  y);
  endtask

  initial begin
    n_tests    = 0;
    n_failed   = 0;
    rst        = 1'b1;
    tick       = 1'b0;
    load_valid = 1'b0;
    load_day   = '0;
    load_month = '0;
    err_clr    = 1'b0;

    // Reset
    step();
    step();
    check_date("rst", 1, 1, 0);
    check("rst.err", int'(err), 0);
    check("rst.ready", int'(load_ready), 0);
    check("rst.mwrap", int'(month_wrap), 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", int'(load_ready), 1);
    check_date("post_rst", 1, 1, 0);

    // Back-to-back ticks through a month rollover
    for (int i = 0; i < 29; i++) do_tick();
    check_date("tick29", 30, 1, 0);
    check("tick29.mwrap", int'(month_wrap), 0);
    do_tick();
    check_date("tick30", 1, 2, 0);
    check("tick30.mwrap", int'(month_wrap), 1);
    check("tick30.ywrap", int'(year_wrap), 0);
    step();
    check("mwrap_one_cycle", int'(month_wrap), 0);

    // Advance to year 5 via end-of-year loads
    for (int i = 0; i < 5; i++) begin
      do_load(30, 12);
      do_tick();
    end
    check_date("year5", 1, 1, 5);
    do_load(30, 12);
    check_date("load_30_12", 30, 12, 5);
    do_tick();
    check_date("year6", 1, 1, 6);
    check("year6.mwrap", int'(month_wrap), 1);
    check("year6.ywrap", int'(year_wrap), 1);
    step();
    check("mwrap_clear", int'(month_wrap), 0);
    check("ywrap_clear", int'(year_wrap), 0);

    // Year counter wrap 127 -> 0
    for (int i = 0; i < 121; i++) begin
      do_load(30, 12);
      do_tick();
    end
    check_date("year127", 1, 1, 127);
    do_load(30, 12);
    do_tick();
    check_date("year_wrap0", 1, 1, 0);
    check("year_wrap0.ywrap", int'(year_wrap), 1);

    // Illegal loads: date frozen, ticks ignored
    do_load(0, 5);
    check("ld_day0.err", int'(err), 1);
    check_date("ld_day0", 1, 1, 0);
    check("ld_day0.ready", int'(load_ready), 1);
    do_tick();
    check_date("err_tick", 1, 1, 0);
    check("err_tick.mwrap", int'(month_wrap), 0);
    do_load(31, 5);
    check("ld_day31.err", int'(err), 1);
    check_date("ld_day31", 1, 1, 0);
    do_load(5, 13);
    check("ld_m13.err", int'(err), 1);
    check_date("ld_m13", 1, 1, 0);
    do_load(7, 0);
    check("ld_m0.err", int'(err), 1);
    err_clr = 1'b1;
    step();
    check("err_clr.err", int'(err), 0);
    check_date("err_clr", 1, 1, 0);
    do_tick();
    check_date("tick_after_clr", 2, 1, 0);

    // Legal load leaves ERROR; boundary legal values
    do_load(31, 1);
    check("err_again", int'(err), 1);
    do_load(30, 12);
    check("legal_exit.err", int'(err), 0);
    check_date("legal_exit", 30, 12, 0);
    do_load(1, 1);
    check_date("ld_1_1", 1, 1, 0);

    // Load and tick in the same cycle: tick dropped
    load_valid = 1'b1;
    load_day   = 5'd10;
    load_month = 4'd3;
    tick       = 1'b1;
    step();
    check_date("load_tick", 10, 3, 0);
    do_tick();
    check_date("load_tick_next", 11, 3, 0);

    // Reset mid-sequence with tick and a load in flight
    do_load(30, 12);
    do_tick();
    do_load(17, 4);
    check_date("pre_rst", 17, 4, 1);
    rst        = 1'b1;
    tick       = 1'b1;
    load_valid = 1'b1;
    load_day   = 5'd9;
    load_month = 4'd9;
    step();
    check_date("mid_rst", 1, 1, 0);
    check("mid_rst.err", int'(err), 0);
    check("mid_rst.ready", int'(load_ready), 0);
    rst = 1'b0;
    step();
    check("mid_rst.ready_after", int'(load_ready), 1);
    check_date("mid_rst_after", 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
